dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 155 +++++++++++++++
 tb/tb_dmem_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding word memory responder with a
// programmable wait-state count before each access.
// Optional feature: define DMEM_BYTE_WRITE_EN to honour req_be on writes;
// without it every non-error write stores the full word.
module dmem_responder #(
    parameter int WORD_SIZE   = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WORD_SIZE-1:0]   req_addr,
    input  logic [WORD_SIZE-1:0]   req_wdata,
    input  logic [WORD_SIZE/8-1:0] req_be,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WORD_SIZE-1:0]   rsp_rdata,
    output logic                   rsp_err
);

    localparam int NB = WORD_SIZE / 8;
    localparam int IW = WORD_SIZE - 2;
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [3:0]           r_count;

    logic                 r_we;
    logic [WORD_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0] r_wdata;
    logic [NB-1:0]        r_be;

    logic [WORD_SIZE-1:0] r_rdata;
    logic                 r_err;

    logic [WORD_SIZE-1:0] r_mem [DEPTH_WORDS];

    logic                 w_accept;
    logic                 w_commit;
    logic [IW-1:0]        w_wordIdx;
    logic [AW-1:0]        w_memIdx;
    logic                 w_addrErr;
    logic [NB-1:0]        w_byteEn;

    // The access happens on the last WAIT edge, using the latched request.
    assign w_accept  = req_valid && (r_state == IDLE);
    assign w_commit  = (r_state == WAIT) && (r_count == 4'd0);
    assign w_wordIdx = r_addr[WORD_SIZE-1:2];
    assign w_memIdx  = w_wordIdx[AW-1:0];
    assign w_addrErr = (r_addr[1:0] != 2'b00) || (w_wordIdx >= IW'(DEPTH_WORDS));

`ifdef DMEM_BYTE_WRITE_EN
    assign w_byteEn = r_be;
`else
    assign w_byteEn = {NB{1'b1}};
    logic w_unusedBe;
    assign w_unusedBe = ^r_be;
`endif

    // State register; reset drops any in-flight access back to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state: one request at a time, response held until taken.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (req_valid) w_nextState = WAIT;
            WAIT: if (r_count == 4'd0) w_nextState = RESP;
            RESP: if (rsp_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Handshake outputs follow the state; response data comes from registers.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = r_rdata;
        rsp_err   = r_err;
        case (r_state)
            IDLE:    req_ready = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Wait-state counter: loaded on acceptance, counts down while waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 4'd0;
        end else if (w_accept) begin
            r_count <= 4'(LATENCY);
        end else if ((r_state == WAIT) && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    // Capture the request fields only on the acceptance edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    // Response registers: loaded at the access edge and held through RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_err <= w_addrErr;
            if (!w_addrErr && !r_we) begin
                r_rdata <= r_mem[w_memIdx];
            end else begin
                r_rdata <= '0;
            end
        end
    end

    // Storage array; contents survive reset, writes land only at the access edge.
    always_ff @(posedge clk) begin
        if (w_commit && r_we && !w_addrErr) begin
            for (int i = 0; i < NB; i++) begin
                if (w_byteEn[i]) begin
                    r_mem[w_memIdx][i*8 +: 8] <= r_wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed transactions against a
// transaction-level memory model, with a per-cycle output compare.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int nChecks = 0;
    int nPass   = 0;
    int edgeCnt = 0;

    // model state: 0 = free, 1 = request pending, 2 = response on offer
    int          mPhase;
    int          mLeft;
    logic        mWe;
    logic [31:0] mAddr;
    logic [31:0] mWdata;
    logic [3:0]  mBe;
    logic [31:0] mRdata;
    logic        mErr;
    logic [31:0] mm [0:DEPTH-1];

    dmem_responder #(
        .WORD_SIZE  (32),
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    // free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // count rising edges so latency can be measured
    initial begin
        forever begin
            @(posedge clk);
            edgeCnt = edgeCnt + 1;
        end
    end

    // compare one value against its expectation and tally the result
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks = nChecks + 1;
        if (actual === expected) begin
            nPass = nPass + 1;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // perform the access the model has pending, straight from the memory rules
    task automatic modelAccess();
        logic [29:0] idx;
        logic [3:0]  mask;
        logic [31:0] word;
        idx = mAddr[31:2];
`ifdef DMEM_BYTE_WRITE_EN
        mask = mBe;
`else
        mask = 4'hF;
`endif
        if ((mAddr[1:0] != 2'b00) || (int'(idx) >= DEPTH)) begin
            mErr   = 1'b1;
            mRdata = 32'h0;
        end else if (mWe) begin
            word = mm[idx[7:0]];
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) word[b*8 +: 8] = mWdata[b*8 +: 8];
            end
            mm[idx[7:0]] = word;
            mErr   = 1'b0;
            mRdata = 32'h0;
        end else begin
            mErr   = 1'b0;
            mRdata = mm[idx[7:0]];
        end
    endtask

    // transaction model: a request answers LAT+1 edges after acceptance
    initial begin
        mPhase = 0;
        mLeft  = 0;
        mRdata = 32'h0;
        mErr   = 1'b0;
        for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mPhase = 0;
                mRdata = 32'h0;
                mErr   = 1'b0;
            end else if (mPhase == 0) begin
                if (req_valid) begin
                    mWe    = req_we;
                    mAddr  = req_addr;
                    mWdata = req_wdata;
                    mBe    = req_be;
                    mLeft  = LAT + 1;
                    mPhase = 1;
                end
            end else if (mPhase == 1) begin
                mLeft = mLeft - 1;
                if (mLeft == 0) begin
                    modelAccess();
                    mPhase = 2;
                end
            end else if (rsp_ready) begin
                mPhase = 0;
            end
        end
    end

    // per-cycle compare of the DUT against the model, away from the rising edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                checkOutput("rst.req_ready", 32'(req_ready), 32'd1);
                checkOutput("rst.rsp_valid", 32'(rsp_valid), 32'd0);
                checkOutput("rst.rsp_rdata", rsp_rdata, 32'h0);
                checkOutput("rst.rsp_err", 32'(rsp_err), 32'd0);
            end else begin
                checkOutput("cyc.req_ready", 32'(req_ready), (mPhase == 0) ? 32'd1 : 32'd0);
                checkOutput("cyc.rsp_valid", 32'(rsp_valid), (mPhase == 2) ? 32'd1 : 32'd0);
                if (mPhase == 2) begin
                    checkOutput("cyc.rsp_rdata", rsp_rdata, mRdata);
                    checkOutput("cyc.rsp_err", 32'(rsp_err), 32'(mErr));
                end
            end
        end
    end

    // one complete transaction; called at a falling edge with the DUT idle
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input int hold, input logic chain,
                                 output logic [31:0] rdata, output logic err);
        int  acc;
        int  n;
        logic seen;
        checkOutput("start.req_ready", 32'(req_ready), 32'd1);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        acc = edgeCnt + 1;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'h0000_0044;
        req_wdata = 32'h5A5A_A5A5;
        req_be    = 4'hF;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            if (rsp_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                n = n + 1;
            end
        end
        if (!seen) begin
            checkOutput("rsp_valid.timeout", 32'd0, 32'd1);
            rdata = 32'hX;
            err   = 1'bX;
            return;
        end
        checkOutput("latency", 32'(edgeCnt - acc), 32'(LAT + 1));
        rdata = rsp_rdata;
        err   = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput("hold.rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold.rsp_rdata", rsp_rdata, rdata);
            checkOutput("hold.rsp_err", 32'(rsp_err), 32'(err));
            checkOutput("hold.req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        if (chain) req_valid = 1'b1;
        @(negedge clk);
        checkOutput("done.req_ready", 32'(req_ready), 32'd1);
        checkOutput("done.rsp_valid", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    // watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // directed scenario list
    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] expByte;

        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_be    = 4'h0;
        rsp_ready = 1'b0;

        // reset and release
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("release.req_ready", 32'(req_ready), 32'd1);
        checkOutput("release.rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("release.rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("release.rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);

        // write then read back
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, rd, er);
        checkOutput("wr10.rdata", rd, 32'h0);
        checkOutput("wr10.err", 32'(er), 32'd0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er);
        checkOutput("rd10.rdata", rd, 32'hDEADBEEF);
        checkOutput("rd10.err", 32'(er), 32'd0);

        // byte enables
`ifdef DMEM_BYTE_WRITE_EN
        expByte = 32'h1122CCDD;
`else
        expByte = 32'hAABBCCDD;
`endif
        applyStimulus(1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0, rd, er);
        applyStimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'h3, 0, 1'b0, rd, er);
        checkOutput("be.wr.err", 32'(er), 32'd0);
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, er);
        checkOutput("be.rd.rdata", rd, expByte);

        // misaligned and out-of-range accesses
        applyStimulus(1'b0, 32'h22, 32'h0, 4'h0, 0, 1'b0, rd, er);
        checkOutput("misalign.err", 32'(er), 32'd1);
        checkOutput("misalign.rdata", rd, 32'h0);
        applyStimulus(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, 1'b0, rd, er);
        applyStimulus(1'b1, 32'h400, 32'h12345678, 4'hF, 0, 1'b0, rd, er);
        checkOutput("range.err", 32'(er), 32'd1);
        checkOutput("range.rdata", rd, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, rd, er);
        checkOutput("range.unchanged", rd, 32'hCAFEF00D);

        // back-pressure, then a request already waiting at the handshake edge
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1, rd, er);
        checkOutput("bp.rdata", rd, 32'hDEADBEEF);
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, er);
        checkOutput("chain.rdata", rd, expByte);

        // reset in the middle of a write
        applyStimulus(1'b1, 32'h30, 32'h12345678, 4'hF, 0, 1'b0, rd, er);
        req_we    = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'h55;
        req_be    = 4'hF;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("midrst.inwait", 32'(req_ready), 32'd0);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst.req_ready", 32'(req_ready), 32'd1);
        checkOutput("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, rd, er);
        checkOutput("midrst.rdata", rd, 32'h12345678);

        repeat (3) @(negedge clk);
        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
